fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RV32I core; replaces the single-cycle "PC register feeds the instruction memory directly" scheme.
- Issues pipelined in-order requests to instruction memory and buffers returned instructions with their PCs in a DEPTH-entry queue.
- Presents instructions to the decoder over a valid/ready handshake.
- Accepts jump/branch redirects that flush the queue and discard stale in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  // fetch_entry_t {pc[XLEN], instr[32], fault} is declared at each use site; this is its width.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return xlen + 33;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and first-word-visible head.
// A push in the same cycle as a flush lands as the sole entry of the emptied queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned EntryW = entry_width(XLEN),
  localparam int unsigned CntW   = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [EntryW-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CntW-1:0]   count_o,
  output logic              head_valid_o,
  output logic [EntryW-1:0] head_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_idx   = flush_i ? '0 : wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = push_i ? PtrW'(1) : '0;
      count_d  = push_i ? CntW'(1) : '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

  // rst_ni is sampled synchronously.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// RV32I fetch front end: pipelined imem requests, credit-limited queue, redirect flush.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned LiveW = CntW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CntW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, occ;
  logic [LiveW-1:0] live;
  logic            req_fire, rsp_take, rsp_keep, trap, push, pop;
  fetch_entry_t    push_entry, head;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Words still owed to the queue: buffered plus non-stale in flight.
  assign live = LiveW'(occ) + LiveW'(outstanding_q) - LiveW'(discard_q);

  always_comb begin
    imem_req_valid = reset && (state_q == RUN) && !redirect_valid &&
                     (live < LiveW'(DEPTH)) && (outstanding_q < CntW'(DEPTH));
    req_fire      = imem_req_valid && imem_req_ready;
    rsp_take      = imem_rsp_valid && (outstanding_q != '0);
    rsp_keep      = rsp_take && (discard_q == '0);
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_take);

    discard_d = discard_q;
    if (redirect_valid) discard_d = outstanding_d;
    else if (rsp_take && !rsp_keep) discard_d = discard_q - CntW'(1);

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
    end

    state_d = state_q;
    if (redirect_valid) state_d = trap ? HALT : RUN;
    else if (state_q == BOOT) state_d = RUN;

    // A redirect flushes; the only word that survives it is the trap marker.
    push = redirect_valid ? trap : rsp_keep;
    if (trap) begin
      push_entry.pc    = redirect_pc;
      push_entry.instr = NOP_INSTR;
      push_entry.fault = 1'b1;
    end else begin
      push_entry.pc    = rsp_pc_q;
      push_entry.instr = imem_rsp_data;
      push_entry.fault = 1'b0;
    end
    pop = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .count_o      (occ),
    .head_valid_o (out_valid),
    .head_data_o  (head)
  );

  assign imem_req_addr = fetch_pc_q;

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign out_fault = out_valid && head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
  assign out_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle vector table, directed corner sequences and a
// randomized run against a stream-level reference model (expected PC stream per redirect epoch).
module tb_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_pc, out_instr;
  logic        redirect_valid, out_valid, out_ready, out_fault;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory model: in-order responses, each tagged with the redirect epoch it was issued in.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;
  mreq_t pend[$];
  int lat_min = 1, lat_max = 1, rdy_pct = 100, last_due = 0;

  // Stream model state.
  int          epoch = 0, held = 0, fires = 0, pops = 0;
  bit          boot = 1'b1, halted = 1'b0, fault_pend = 1'b0;
  logic [31:0] exp_req_addr = 32'h0, exp_out_pc = 32'h0, trap_pc = 32'h0, last_fire_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe();
    int          cur_pend;
    bit          exp_req, exp_ov;
    int          lat;
    mreq_t       m;
    if (!reset) begin
      check("req_valid_in_reset", imem_req_valid, 0);
      pend.delete();
      held = 0; boot = 1'b1; halted = 1'b0; fault_pend = 1'b0; epoch++;
      exp_req_addr = 32'h0; exp_out_pc = 32'h0; last_due = 0;
      return;
    end
    cur_pend = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) cur_pend++;
    exp_req = !boot && !halted && !redirect_valid && (held + cur_pend < DEPTH) &&
              (pend.size() < DEPTH);
    check("req_valid", imem_req_valid, exp_req);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      lat = $urandom_range(lat_max, lat_min);
      m.addr = imem_req_addr; m.epoch = epoch; m.due = cyc + lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      pend.push_back(m);
      exp_req_addr += 32'd4;
      fires++;
      last_fire_addr = imem_req_addr;
    end
    exp_ov = fault_pend || (held > 0);
    check("out_valid", out_valid, exp_ov);
    if (out_valid && fault_pend) begin
      check("trap_pc", out_pc, trap_pc);
      check("trap_instr", out_instr, 32'h0000_0013);
      check("trap_fault", out_fault, 1);
    end else if (out_valid) begin
      check("out_pc", out_pc, exp_out_pc);
      check("out_instr", out_instr, mem_word(exp_out_pc));
      check("out_fault", out_fault, 0);
    end
    if (out_valid && out_ready && exp_ov) begin
      if (fault_pend) fault_pend = 1'b0;
      else begin
        held--; exp_out_pc += 32'd4; pops++;
      end
    end
    if (imem_rsp_valid) begin
      m = pend.pop_front();
      if (m.epoch == epoch) held++;
    end
    if (redirect_valid) begin
      epoch++; held = 0; fault_pend = 1'b0; halted = 1'b0;
      exp_req_addr = redirect_pc & ~32'h3;
      exp_out_pc   = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        halted = 1'b1; fault_pend = 1'b1; trap_pc = redirect_pc;
      end
`endif
    end
    boot = 1'b0;
  endtask

  task automatic drive_mem();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
      end
    end
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
  endtask

  task automatic step();
    #1;
    observe();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_mem();
  endtask

  task automatic redirect_step(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_fault", out_fault, 0);
    check("rst_boot_no_req", imem_req_valid, 0);
  endtask

  task automatic wait_fire(input string name, input int bound);
    int base = fires;
    int n = 0;
    while (fires == base && n < bound) begin step(); n++; end
    check(name, (fires != base), 1);
  endtask

  task automatic wait_out(input string name, input int bound);
    int n = 0;
    #1;
    while (!out_valid && n < bound) begin step(); #1; n++; end
    check(name, out_valid, 1);
  endtask

  typedef struct {
    bit          ordy;
    bit          rv;
    logic [31:0] ra;
    bit          ov;
    logic [31:0] opc;
  } vec_t;

  vec_t tbl[17];
  int   base, pbase;

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Startup with 1-cycle memory, then a 4-cycle decoder stall and release.
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[8]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    tbl[15] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
    tbl[16] = '{1'b1, 1'b1, 32'h30, 1'b1, 32'h24};

    drive_mem();
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].rv);
      if (tbl[i].rv) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].ra);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].opc);
        check($sformatf("tbl%0d_out_instr", i), out_instr, mem_word(tbl[i].opc));
      end
      step();
    end

    // Stall from reset: exactly DEPTH requests, head held, then drain and resume at 0x10.
    out_ready = 1'b0;
    reset_dut();
    base = fires;
    repeat (20) step();
    check("stall_req_count", fires - base, DEPTH);
    #1;
    check("stall_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    pbase = pops;
    wait_fire("resume_fire", 10);
    check("resume_addr", last_fire_addr, 32'h10);
    repeat (6) step();
    check("drain_pops", (pops - pbase >= 4), 1);

    // Redirect with 3 responses in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    reset_dut();
    for (int n = 0; n < 20 && pend.size() < 3; n++) step();
    check("three_in_flight", (pend.size() >= 3), 1);
    redirect_step(32'h100);
    wait_out("redir_out", 20);
    check("redir_pc", out_pc, 32'h100);
    check("redir_instr", out_instr, mem_word(32'h100));

    // Back-to-back redirects two cycles apart.
    repeat (4) step();
    redirect_step(32'h200);
    step();
    redirect_step(32'h300);
    wait_out("redir2_out", 20);
    check("redir2_pc", out_pc, 32'h300);
    repeat (20) step();

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    redirect_step(32'hFFFF_FFFC);
    wait_fire("wrap_fire0", 10);
    check("wrap_addr0", last_fire_addr, 32'hFFFF_FFFC);
    wait_fire("wrap_fire1", 10);
    check("wrap_addr1", last_fire_addr, 32'h0);
    repeat (6) step();

    // Misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
    out_ready = 1'b0;
    redirect_step(32'h102);
    #1;
    check("trap_valid", out_valid, 1);
    check("trap_head_pc", out_pc, 32'h102);
    check("trap_head_fault", out_fault, 1);
    base = fires;
    repeat (5) step();
    check("trap_no_req", fires - base, 0);
    out_ready = 1'b1;
    step();
    redirect_step(32'h40);
    wait_out("trap_exit_out", 20);
    check("trap_exit_pc", out_pc, 32'h40);
`else
    redirect_step(32'h102);
    wait_out("misalign_out", 20);
    check("misalign_pc", out_pc, 32'h100);
    check("misalign_fault", out_fault, 0);
`endif
    repeat (5) step();

    // Randomized run with variable latency, backpressure, redirects and resets.
    rdy_pct = 70;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) lat_max = $urandom_range(5, 1);
      out_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(799, 0) == 0) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end else if (!boot && $urandom_range(39, 0) == 0) begin
        if ($urandom_range(9, 0) == 0) redirect_step(32'hFFFF_FFF0);
        else if ($urandom_range(3, 0) == 0) redirect_step(($urandom & 32'hFFC) | 32'h2);
        else redirect_step($urandom & 32'hFFC);
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
